// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer, one result bit per cycle.
// MUL is radix-2 shift-add, DIV is restoring division. The shared
// accumulator {hi_q, lo_q} holds {0, a} during MUL and {remainder, quotient}
// during DIV.
//
// Handshake: the requester raises start and holds it (with op/a/b stable)
// until it samples busy=0 at a rising edge. Start is accepted only at an
// edge where the FSM is in IDLE. busy stays high until the cycle after the
// single-cycle done pulse. Results stay registered until the next done.
module muldiv_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_lo_q, res_lo_d;
  logic [N-1:0]  res_hi_q, res_hi_d;
  logic          dbz_q, dbz_d;

  // Single-iteration datapath results, used by the MUL and DIV states.
  logic [N:0]   mul_sum;
  logic [N-1:0] mul_hi, mul_lo;
  logic [N:0]   div_shrem, div_trial;
  logic [N-1:0] div_rem, div_quo;
  logic         last_iter;

  // One shift-add step and one restoring-divide step from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
    mul_hi    = mul_sum[N:1];
    mul_lo    = {mul_sum[0], lo_q[N-1:1]};
    div_shrem = {hi_q, lo_q[N-1]};
    div_trial = div_shrem - {1'b0, b_q};
    div_rem   = div_trial[N] ? div_shrem[N-1:0] : div_trial[N-1:0];
    div_quo   = {lo_q[N-2:0], ~div_trial[N]};
    last_iter = (cnt_q == LAST_ITER);
  end

  // Next-state and datapath control for the IDLE/MUL/DIV/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d   = b;
          hi_d  = '0;
          lo_d  = a;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (!op) begin
            state_d = S_MUL;
          end else if (b != '0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero finishes immediately with a fixed result pattern.
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = a;
            dbz_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = S_DONE;
          res_hi_d = mul_hi;
          res_lo_d = mul_lo;
        end
      end
      S_DIV: begin
        hi_d  = div_rem;
        lo_d  = div_quo;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = S_DONE;
          res_hi_d = div_rem;
          res_lo_d = div_quo;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight and clears results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule
